// File: rtl/remote_comm_pkt_pkg.sv
// Shared FSM encoding and counter-width helpers for the remote-link
// packet command/response engine.
package remote_comm_pkt_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE      = 2'd0;
   localparam state_t S_LOAD      = 2'd1;
   localparam state_t S_WAIT_TX   = 2'd2;
   localparam state_t S_WAIT_RESP = 2'd3;

   // Byte counters carry one spare bit so the full count is representable.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int timeout_width(input int cyc);
      return $clog2(cyc);
   endfunction

endpackage

// File: rtl/remote_comm_pkt_uart.sv
// 8N1 UART transceiver: one transmitter and one receiver sharing a baud
// divisor. tx_done is a level cleared by trmt; rx_rdy is a level cleared by clr_rx_rdy.
module remote_comm_pkt_uart #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   output logic       rx_rdy,
   input  logic       clr_rx_rdy,
   output logic [7:0] rx_data,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done
);

   localparam int BW = $clog2(BAUD_DIV) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

   logic          tx_busy_q;
   logic [8:0]    tx_shift_q;
   logic [3:0]    tx_bits_q;
   logic [BW-1:0] tx_baud_q;
   logic          tx_done_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_bits_q  <= '0;
         tx_baud_q  <= '0;
         tx_done_q  <= 1'b0;
      end else if (trmt) begin
         tx_shift_q <= {tx_data, 1'b0};
         tx_bits_q  <= '0;
         tx_baud_q  <= '0;
         tx_busy_q  <= 1'b1;
         tx_done_q  <= 1'b0;
      end else if (tx_busy_q) begin
         if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q  <= '0;
            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            tx_bits_q  <= tx_bits_q + 1'b1;
            if (tx_bits_q == 4'd9) begin
               tx_busy_q <= 1'b0;
               tx_done_q <= 1'b1;
            end
         end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
         end
      end
   end

   assign TX      = tx_shift_q[0];
   assign tx_done = tx_done_q;

   logic          rx_meta_q, rx_sync_q;
   logic          rx_busy_q;
   logic [3:0]    rx_bits_q;
   logic [BW-1:0] rx_baud_q;
   logic [7:0]    rx_shift_q;
   logic          rx_rdy_q;

   // Sample at mid-bit: first wait is half a period from the start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_bits_q  <= '0;
         rx_baud_q  <= '0;
         rx_shift_q <= '0;
         rx_rdy_q   <= 1'b0;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
         if (clr_rx_rdy) rx_rdy_q <= 1'b0;
         if (!rx_busy_q) begin
            if (!rx_sync_q) begin
               rx_busy_q <= 1'b1;
               rx_baud_q <= BAUD_HALF;
               rx_bits_q <= '0;
            end
         end else if (rx_baud_q == '0) begin
            rx_baud_q <= BAUD_LAST;
            rx_bits_q <= rx_bits_q + 1'b1;
            if (rx_bits_q == 4'd9) begin
               rx_busy_q <= 1'b0;
               rx_rdy_q  <= 1'b1;
            end else if (rx_bits_q != 4'd0) begin
               rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            end
         end else begin
            rx_baud_q <= rx_baud_q - 1'b1;
         end
      end
   end

   assign rx_rdy  = rx_rdy_q;
   assign rx_data = rx_shift_q;

endmodule

// File: rtl/remote_comm_pkt.sv
// Packet-level UART command/response engine: sends a CMD_BYTES command MS
// byte first, then assembles a RESP_BYTES response or flags a timeout.
module remote_comm_pkt
   import remote_comm_pkt_pkg::*;
#(
   parameter int CMD_BYTES   = 2,
   parameter int RESP_BYTES  = 1,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int BAUD_DIV    = 2604
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    send_cmd,
   input  logic [8*CMD_BYTES-1:0]  cmd,
   input  logic                    clr_resp_rdy,
   input  logic                    RX,
   output logic                    TX,
   output logic                    busy,
   output logic                    cmd_sent,
   output logic [8*RESP_BYTES-1:0] resp,
   output logic                    resp_rdy,
   output logic                    resp_timeout
);

   localparam int CW    = 8 * CMD_BYTES;
   localparam int RW    = 8 * RESP_BYTES;
   localparam int TXC_W = cnt_width(CMD_BYTES);
   localparam int RXC_W = cnt_width(RESP_BYTES);
   localparam int TO_W  = timeout_width(TIMEOUT_CYC);

   localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(CMD_BYTES - 1);
   localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RESP_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_TERM = TO_W'(TIMEOUT_CYC - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    shift_q, shift_d;
   logic [TXC_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [RXC_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [RW-1:0]    resp_q, resp_d;
   logic             cmd_sent_q, cmd_sent_d;
   logic             resp_rdy_q, resp_rdy_d;
   logic             resp_timeout_q, resp_timeout_d;

   logic       trmt, tx_done, rx_rdy, clr_rx_rdy;
   logic [7:0] tx_data, rx_data;

   remote_comm_pkt_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (clr_rx_rdy),
      .rx_data    (rx_data),
      .trmt       (trmt),
      .tx_data    (tx_data),
      .tx_done    (tx_done)
   );

   assign trmt    = (state_q == S_LOAD);
   assign tx_data = shift_q[CW-1 -: 8];
   // Every received byte is consumed at once: accepted in WAIT_RESP, discarded elsewhere.
   assign clr_rx_rdy = rx_rdy;

   // NOTE: every next-state signal gets a default before the case so no
   // path leaves one unassigned and infers a latch.
   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      tx_cnt_d       = tx_cnt_q;
      rx_cnt_d       = rx_cnt_q;
      to_cnt_d       = to_cnt_q;
      resp_d         = resp_q;
      cmd_sent_d     = cmd_sent_q;
      resp_rdy_d     = resp_rdy_q & ~clr_resp_rdy;
      resp_timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (send_cmd) begin
               shift_d    = cmd;
               tx_cnt_d   = '0;
               cmd_sent_d = 1'b0;
               resp_rdy_d = 1'b0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: state_d = S_WAIT_TX;
         S_WAIT_TX: begin
            if (tx_done) begin
               if (tx_cnt_q == TX_LAST) begin
                  cmd_sent_d = 1'b1;
                  rx_cnt_d   = '0;
                  to_cnt_d   = '0;
                  state_d    = S_WAIT_RESP;
               end else begin
                  shift_d  = shift_q << 8;
                  tx_cnt_d = tx_cnt_q + 1'b1;
                  state_d  = S_LOAD;
               end
            end
         end
         S_WAIT_RESP: begin
            // A byte arriving on the terminal count beats the timeout.
            if (rx_rdy) begin
               resp_d   = RW'({resp_q, rx_data});
               rx_cnt_d = rx_cnt_q + 1'b1;
               to_cnt_d = '0;
               if (rx_cnt_q == RX_LAST) begin
                  resp_rdy_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end else if (to_cnt_q == TO_TERM) begin
               resp_timeout_d = 1'b1;
               state_d        = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         shift_q        <= '0;
         tx_cnt_q       <= '0;
         rx_cnt_q       <= '0;
         to_cnt_q       <= '0;
         resp_q         <= '0;
         cmd_sent_q     <= 1'b0;
         resp_rdy_q     <= 1'b0;
         resp_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         tx_cnt_q       <= tx_cnt_d;
         rx_cnt_q       <= rx_cnt_d;
         to_cnt_q       <= to_cnt_d;
         resp_q         <= resp_d;
         cmd_sent_q     <= cmd_sent_d;
         resp_rdy_q     <= resp_rdy_d;
         resp_timeout_q <= resp_timeout_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign cmd_sent     = cmd_sent_q;
   assign resp         = resp_q;
   assign resp_rdy     = resp_rdy_q;
   assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_remote_comm_pkt.sv
// Bench for remote_comm_pkt: a 2/1-byte instance and a 4/2-byte instance,
// driven by a bench UART and checked against an arithmetic packet model.
module tb_remote_comm_pkt;

   localparam int BAUD = 8;
   localparam int TO   = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 4-byte command, 2-byte response
   logic        send_a = 1'b0;
   logic [31:0] cmd_a  = '0;
   logic        clr_a  = 1'b0;
   logic        rx_a   = 1'b1;
   logic        tx_a, busy_a, sent_a, rdy_a, to_a;
   logic [15:0] resp_a;

   // Instance B: 2-byte command, 1-byte response
   logic        send_b = 1'b0;
   logic [15:0] cmd_b  = '0;
   logic        clr_b  = 1'b0;
   logic        rx_b   = 1'b1;
   logic        tx_b, busy_b, sent_b, rdy_b, to_b;
   logic [7:0]  resp_b;

   remote_comm_pkt #(.CMD_BYTES(4), .RESP_BYTES(2), .TIMEOUT_CYC(TO), .BAUD_DIV(BAUD)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .send_cmd(send_a), .cmd(cmd_a), .clr_resp_rdy(clr_a),
      .RX(rx_a), .TX(tx_a), .busy(busy_a), .cmd_sent(sent_a), .resp(resp_a),
      .resp_rdy(rdy_a), .resp_timeout(to_a));

   remote_comm_pkt #(.CMD_BYTES(2), .RESP_BYTES(1), .TIMEOUT_CYC(TO), .BAUD_DIV(BAUD)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .send_cmd(send_b), .cmd(cmd_b), .clr_resp_rdy(clr_b),
      .RX(rx_b), .TX(tx_b), .busy(busy_b), .cmd_sent(sent_b), .resp(resp_b),
      .resp_rdy(rdy_b), .resp_timeout(to_b));

   int errors = 0;
   int checks = 0;
   int exp1   = 0;   // model of instance A's response register

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serial decoders for both TX pins; bytes are appended, never removed.
   logic [7:0] txq_a[$];
   logic [7:0] txq_b[$];

   always begin : mon_a
      logic [7:0] b;
      @(negedge tx_a);
      repeat (BAUD + BAUD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         b[i] = tx_a;
         repeat (BAUD) @(negedge clk);
      end
      txq_a.push_back(b);
   end

   always begin : mon_b
      logic [7:0] b;
      @(negedge tx_b);
      repeat (BAUD + BAUD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         b[i] = tx_b;
         repeat (BAUD) @(negedge clk);
      end
      txq_b.push_back(b);
   end

   // Event timestamps for instance A, in negedge counts.
   int          cyc_n = 0, t_sent = 0, t_to = 0, t_resp = 0;
   int          to_total = 0, trmt_total = 0;
   logic        sent_prev = 1'b0;
   logic [15:0] resp_prev = '0;

   always @(negedge clk) begin
      cyc_n++;
      if (sent_a === 1'b1 && sent_prev !== 1'b1) t_sent = cyc_n;
      sent_prev = sent_a;
      if (to_a === 1'b1) begin
         to_total++;
         t_to = cyc_n;
      end
      if (resp_a !== resp_prev) t_resp = cyc_n;
      resp_prev = resp_a;
      if (u_dut1.trmt === 1'b1) trmt_total++;
   end

   task automatic uart_send(input bit which, input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (which) rx_b = frame[i];
         else       rx_a = frame[i];
         repeat (BAUD) @(negedge clk);
      end
   endtask

   task automatic wait_sent1(input string tag);
      int n;
      n = 0;
      while (sent_a !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_cmd_sent"}, sent_a, 1'b1);
   endtask

   task automatic wait_idle1(input string tag);
      int n;
      n = 0;
      while (busy_a !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, busy_a, 1'b0);
      @(negedge clk);
   endtask

   task automatic send1(input logic [31:0] c);
      @(negedge clk);
      cmd_a  = c;
      send_a = 1'b1;
      @(negedge clk);
      send_a = 1'b0;
   endtask

   function automatic int fold(input int acc, input logic [7:0] b);
      return (acc * 256 + int'(b)) % 65536;
   endfunction

   task automatic check_tx1(input string tag, input logic [31:0] c, input int base);
      logic [7:0] e, o;
      for (int i = 0; i < 4; i++) begin
         e = 8'(c >> (8 * (3 - i)));
         o = (txq_a.size() > base + i) ? txq_a[base + i] : 8'hxx;
         check($sformatf("%s_txbyte%0d", tag, i), o, e);
      end
   endtask

   // Full packet on instance A; dup issues a second send_cmd mid-transfer.
   task automatic run_pkt1(input string tag, input logic [31:0] c, input logic [7:0] b0,
                           input logic [7:0] b1, input int gap, input bit dup);
      int base, tr0, to0;
      base = txq_a.size();
      tr0  = trmt_total;
      to0  = to_total;
      send1(c);
      check({tag, "_busy"}, busy_a, 1'b1);
      check({tag, "_rdy_cleared"}, rdy_a, 1'b0);
      if (dup) begin
         repeat (30) @(negedge clk);
         cmd_a  = ~c;
         send_a = 1'b1;
         @(negedge clk);
         send_a = 1'b0;
      end
      wait_sent1(tag);
      check_tx1(tag, c, base);
      repeat (gap) @(negedge clk);
      uart_send(1'b0, b0);
      exp1 = fold(exp1, b0);
      repeat (gap) @(negedge clk);
      uart_send(1'b0, b1);
      exp1 = fold(exp1, b1);
      wait_idle1(tag);
      check({tag, "_resp"}, resp_a, exp1);
      check({tag, "_resp_rdy"}, rdy_a, 1'b1);
      check({tag, "_sent_held"}, sent_a, 1'b1);
      check({tag, "_trmt_count"}, trmt_total - tr0, 4);
      check({tag, "_no_timeout"}, to_total - to0, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          base, tr0, to0, n;
      logic [31:0] c;
      logic [7:0]  b;

      // Reset state
      #12;
      check("rst_busy_a", busy_a, 1'b0);
      check("rst_sent_a", sent_a, 1'b0);
      check("rst_resp_a", resp_a, 16'h0);
      check("rst_rdy_a", rdy_a, 1'b0);
      check("rst_to_a", to_a, 1'b0);
      check("rst_tx_a", tx_a, 1'b1);
      check("rst_busy_b", busy_b, 1'b0);
      check("rst_resp_b", resp_b, 8'h0);
      check("rst_tx_b", tx_b, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Instance B: 16'hA55A out, 8'hA5 echoed back
      base = txq_b.size();
      @(negedge clk);
      cmd_b  = 16'hA55A;
      send_b = 1'b1;
      @(negedge clk);
      send_b = 1'b0;
      check("b_busy", busy_b, 1'b1);
      n = 0;
      while (sent_b !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("b_cmd_sent", sent_b, 1'b1);
      check("b_txbyte0", (txq_b.size() > base) ? txq_b[base] : 8'hxx, 8'hA5);
      check("b_txbyte1", (txq_b.size() > base + 1) ? txq_b[base + 1] : 8'hxx, 8'h5A);
      check("b_txcount", txq_b.size() - base, 2);
      uart_send(1'b1, 8'hA5);
      n = 0;
      while (rdy_b !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b_resp_rdy", rdy_b, 1'b1);
      check("b_resp", resp_b, 8'hA5);
      check("b_busy_low", busy_b, 1'b0);

      // Instance A directed, then randomized packets
      run_pkt1("a_dir", 32'h12345678, 8'hBE, 8'hEF, 0, 1'b0);
      check("a_dir_beef", resp_a, 16'hBEEF);
      for (int i = 0; i < 4; i++)
         run_pkt1($sformatf("a_rnd%0d", i), $urandom, 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 40)), 1'b0);

      // Host acknowledge clears resp_rdy only
      @(negedge clk);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clr_rdy", rdy_a, 1'b0);
      check("clr_resp_kept", resp_a, exp1);

      // Silent responder: timeout TO cycles after cmd_sent
      to0 = to_total;
      send1($urandom);
      wait_sent1("silent");
      wait_idle1("silent");
      check("silent_to_pulses", to_total - to0, 1);
      check("silent_to_delay", t_to - t_sent, TO);
      check("silent_rdy", rdy_a, 1'b0);
      check("silent_resp", resp_a, exp1);
      check("silent_sent", sent_a, 1'b1);

      // One byte then silence: timeout restarts at that byte
      to0 = to_total;
      send1($urandom);
      wait_sent1("partial");
      repeat (20) @(negedge clk);
      b = 8'($urandom);
      if (fold(exp1, b) == exp1) b = b ^ 8'h01;
      uart_send(1'b0, b);
      exp1 = fold(exp1, b);
      wait_idle1("partial");
      check("partial_to_pulses", to_total - to0, 1);
      check("partial_to_delay", t_to - t_resp, TO);
      check("partial_resp", resp_a, exp1);
      check("partial_rdy", rdy_a, 1'b0);

      // Second send_cmd while busy is ignored
      run_pkt1("dup", $urandom, 8'($urandom), 8'($urandom), 5, 1'b1);

      // Stray byte in IDLE is discarded
      tr0 = trmt_total;
      uart_send(1'b0, 8'($urandom));
      repeat (10) @(negedge clk);
      check("stray_resp", resp_a, exp1);
      check("stray_rx_cleared", u_dut1.rx_rdy, 1'b0);
      check("stray_busy", busy_a, 1'b0);
      check("stray_no_trmt", trmt_total - tr0, 0);

      // Reset during the second command byte
      tr0 = trmt_total;
      send1($urandom);
      n = 0;
      while (trmt_total - tr0 < 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reached", trmt_total - tr0, 2);
      repeat (20) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_busy", busy_a, 1'b0);
      check("rstmid_sent", sent_a, 1'b0);
      check("rstmid_resp", resp_a, 16'h0);
      check("rstmid_rdy", rdy_a, 1'b0);
      check("rstmid_to", to_a, 1'b0);
      check("rstmid_tx", tx_a, 1'b1);
      exp1 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * BAUD) @(negedge clk);
      c = $urandom;
      run_pkt1("post_rst", c, 8'($urandom), 8'($urandom), 3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/remote_comm_pkt.md
Name: remote_comm_pkt

Overview:
Parametrised packet-level UART command/response engine for the Knight follower's remote link. Accepts a CMD_BYTES-wide command and serialises it MS byte first over one UART instance. It then collects a RESP_BYTES-wide response into a single word. A response that does not arrive within TIMEOUT_CYC clocks is flagged. Sits between the host-side command generator and the TX/RX pins, and replaces the fixed 2-byte/1-byte command sender.

Parameters:
CMD_BYTES, 2, number of command bytes sent per packet (1..8)
RESP_BYTES, 1, number of response bytes expected per packet (1..4)
TIMEOUT_CYC, 1000000, max clk cycles allowed between cmd_sent rising and each response byte (>=16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
send_cmd  in  1  single-cycle request; starts a packet when idle
cmd  in  8*CMD_BYTES  command word, sampled only in the cycle send_cmd is accepted
clr_resp_rdy  in  1  host acknowledge; clears resp_rdy
RX  in  1  UART serial input
TX  out  1  UART serial output
busy  out  1  high from send_cmd acceptance until response complete or timeout
cmd_sent  out  1  level; set when last command byte finishes transmitting
resp  out  8*RESP_BYTES  assembled response; first received byte in MS position
resp_rdy  out  1  level; set when all RESP_BYTES bytes have been received
resp_timeout  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset values: busy=0, cmd_sent=0, resp=0, resp_rdy=0, resp_timeout=0. The FSM returns to IDLE and all counters clear. TX idles high via the UART.
- States: IDLE, LOAD, WAIT_TX, WAIT_RESP.
- IDLE:
  - When send_cmd=1, latch cmd into a shift register, set tx_cnt=0, clear cmd_sent and resp_rdy, and go to LOAD. busy rises on the next edge.
  - send_cmd is ignored in every state other than IDLE (no queueing).
- LOAD: pulse UART trmt for exactly one cycle with tx_data = shift_reg MS byte, then go to WAIT_TX.
- WAIT_TX: on tx_done:
  - if tx_cnt==CMD_BYTES-1: set cmd_sent, clear rx_cnt and the timeout counter, go to WAIT_RESP.
  - otherwise: shift the register left 8, increment tx_cnt, go to LOAD.
  - Inter-byte gap is one cycle (LOAD) after tx_done.
- WAIT_RESP:
  - The timeout counter increments every cycle.
  - On UART rx_rdy: resp <= {resp[8*RESP_BYTES-9:0], rx_data}, pulse clr_rx_rdy for one cycle, increment rx_cnt, and zero the timeout counter.
  - On the byte making rx_cnt==RESP_BYTES: set resp_rdy in the same edge that loads the final byte, then go to IDLE (busy falls).
  - If the timeout counter reaches TIMEOUT_CYC-1 with no rx_rdy: pulse resp_timeout, go to IDLE. resp keeps the partial contents and resp_rdy stays 0.
  - If rx_rdy and the timeout terminal count occur in the same cycle, rx_rdy wins: the byte is accepted and no timeout fires.
- Stray RX bytes outside WAIT_RESP (IDLE, LOAD, WAIT_TX) are discarded: clr_rx_rdy is pulsed and resp is unchanged.
- resp_rdy clears on clr_resp_rdy or on acceptance of a new send_cmd. clr_resp_rdy and a final-byte set in the same cycle: set wins.
- cmd_sent stays high after packet completion until the next accepted send_cmd.
- Widths:
  - tx_cnt is $clog2(CMD_BYTES)+1 bits.
  - rx_cnt is $clog2(RESP_BYTES)+1 bits.
  - timeout counter is $clog2(TIMEOUT_CYC) bits and saturates at terminal count (no wrap).
- Reset asserted mid-packet aborts immediately. No partial byte or flag survives.

Decomposition:
- remote_comm_pkg: the state enum typedef (2-bit), and localparam helper functions for counter widths.
- One sub-module: the existing UART transceiver (clk, rst_n, RX, TX, rx_rdy, clr_rx_rdy, rx_data, trmt, tx_data, tx_done), instantiated once.
- No other sub-modules. The FSM, shift register, response assembler and timeout counter live in this block.

Test Plan:
- CMD_BYTES=2, RESP_BYTES=1; send_cmd with cmd=16'hA55A; bench UART echoes 8'hA5 -> TX carries bytes A5 then 5A; cmd_sent rises after the second tx_done; resp=8'hA5, resp_rdy=1, busy=0.
- CMD_BYTES=4, RESP_BYTES=2; cmd=32'h12345678; responder sends 8'hBE, 8'hEF -> four bytes 12,34,56,78 in order; resp=16'hBEEF; exactly 4 trmt pulses.
- TIMEOUT_CYC=200; responder silent -> resp_timeout pulses once, 200 cycles after cmd_sent; busy=0; resp_rdy=0.
- RESP_BYTES=2, TIMEOUT_CYC=200; responder sends one byte then goes silent -> timeout counter restarts at the byte; resp_timeout 200 cycles after that byte; resp low byte holds the partial data.
- Second send_cmd issued while busy, and a stray RX byte injected in IDLE -> second command ignored (no extra trmt); stray byte cleared; resp unchanged.
- rst_n asserted during the second command byte -> all outputs zero asynchronously; TX high; a following send_cmd completes a normal packet.
